// File: rtl/enoc_input_buffer.sv
// ---------------------------------------------------------------------------
// enoc_input_buffer
//
// Per-port input FIFO sitting directly upstream of an ENoC router port's
// route calculator. Arriving packets are stored with their X/Y/Z destination
// fields. The head packet's destination is presented to the route calculator,
// and the head is popped when the switch allocator grants it. o_en tells the
// upstream link whether it may send this cycle.
//
// Optional feature macro: ENOC_INPUT_BYPASS_EN
//   When defined, a packet arriving at an empty buffer drives the head
//   outputs combinationally in the same cycle. If it is granted in that
//   cycle it is consumed without ever being written.
//
// Ports
//   clk       in   1           rising-edge clock
//   reset     in   1           synchronous, active-high
//   i_data    in   DATA_WIDTH  incoming payload
//   i_x_dest  in   XW          incoming X destination
//   i_y_dest  in   YW          incoming Y destination
//   i_z_dest  in   ZW          incoming Z destination
//   i_val     in   1           incoming packet valid
//   o_en      out  1           upstream may send (buffer not full)
//   o_data    out  DATA_WIDTH  head payload
//   o_x_dest  out  XW          head X destination
//   o_y_dest  out  YW          head Y destination
//   o_z_dest  out  ZW          head Z destination
//   o_val     out  1           head valid
//   i_grant   in   1           allocator accepted the head this cycle
//   o_count   out  AW+1        current occupancy, 0..DEPTH
//
// Destination widths are log2(N_NODES), widened to 1 bit when N_NODES is 1
// so that a single-layer (Z_NODES=1) network still has a legal port width.
// ---------------------------------------------------------------------------
module enoc_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int X_NODES    = 4,
  parameter int Y_NODES    = 4,
  parameter int Z_NODES    = 1,
  parameter int DEPTH      = 4,
  localparam int XW = (X_NODES > 1) ? $clog2(X_NODES) : 1,
  localparam int YW = (Y_NODES > 1) ? $clog2(Y_NODES) : 1,
  localparam int ZW = (Z_NODES > 1) ? $clog2(Z_NODES) : 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [XW-1:0]         i_x_dest,
  input  logic [YW-1:0]         i_y_dest,
  input  logic [ZW-1:0]         i_z_dest,
  input  logic                  i_val,
  output logic                  o_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [XW-1:0]         o_x_dest,
  output logic [YW-1:0]         o_y_dest,
  output logic [ZW-1:0]         o_z_dest,
  output logic                  o_val,
  input  logic                  i_grant,
  output logic [CW-1:0]         o_count
);

  localparam int EW = DATA_WIDTH + XW + YW + ZW;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          stored_val;
  logic          bypass_active;
  logic          push;
  logic          pop;
  logic [EW-1:0] in_entry;
  logic [EW-1:0] head_entry;

  assign in_entry   = {i_data, i_x_dest, i_y_dest, i_z_dest};
  assign stored_val = (count != '0);

  // o_en looks only at the registered count, so a full buffer refuses a
  // push even if the head is popped in the same cycle.
  assign o_en    = (count != CW'(DEPTH));
  assign o_count = count;

`ifdef ENOC_INPUT_BYPASS_EN
  assign bypass_active = !stored_val && i_val;
`else
  assign bypass_active = 1'b0;
`endif

  assign o_val = stored_val || bypass_active;

  // A bypassed packet that is granted immediately never enters storage.
  assign push = i_val && o_en && !(bypass_active && i_grant);
  assign pop  = i_grant && stored_val;

  // Head selection: stored head first, then the bypassed packet, otherwise
  // zeros so the route calculator never sees stale RAM contents.
  always_comb begin
    head_entry = '0;
    if (stored_val) begin
      head_entry = mem[rd_ptr];
    end else if (bypass_active) begin
      head_entry = in_entry;
    end
  end

  assign {o_data, o_x_dest, o_y_dest, o_z_dest} = head_entry;

  // Pointer and occupancy state. Pointers are exactly log2(DEPTH) bits, so
  // incrementing past DEPTH-1 wraps to 0 naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array carries no reset; contents are only ever read at
  // positions the pointers mark as occupied.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

endmodule

// File: tb/tb_enoc_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_enoc_input_buffer
//
// Directed self-checking bench for enoc_input_buffer with default parameters
// (DATA_WIDTH=32, 4x4x1 nodes, DEPTH=4). Expected behaviour of the optional
// ENOC_INPUT_BYPASS_EN feature follows the same macro.
// ---------------------------------------------------------------------------
module tb_enoc_input_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_data;
  logic [1:0]  i_x_dest;
  logic [1:0]  i_y_dest;
  logic [0:0]  i_z_dest;
  logic        i_val;
  logic        o_en;
  logic [31:0] o_data;
  logic [1:0]  o_x_dest;
  logic [1:0]  o_y_dest;
  logic [0:0]  o_z_dest;
  logic        o_val;
  logic        i_grant;
  logic [2:0]  o_count;

  int checks   = 0;
  int failures = 0;

  enoc_input_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .i_data   (i_data),
    .i_x_dest (i_x_dest),
    .i_y_dest (i_y_dest),
    .i_z_dest (i_z_dest),
    .i_val    (i_val),
    .o_en     (o_en),
    .o_data   (o_data),
    .o_x_dest (o_x_dest),
    .o_y_dest (o_y_dest),
    .o_z_dest (o_z_dest),
    .o_val    (o_val),
    .i_grant  (i_grant),
    .o_count  (o_count)
  );

  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_val    = 1'b0;
    i_grant  = 1'b0;
    i_data   = '0;
    i_x_dest = '0;
    i_y_dest = '0;
    i_z_dest = '0;
  endtask

  task automatic push_one(input logic [31:0] d, input logic [1:0] x, input logic [1:0] y);
    i_val    = 1'b1;
    i_data   = d;
    i_x_dest = x;
    i_y_dest = y;
    tick();
    i_val    = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    i_val   = 1'b1;
    i_data  = 32'hDEAD;
    i_grant = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++; if (o_val !== 1'b0) begin failures++; $display("[TB] FAIL reset_val got=%0b exp=0", o_val); end
    checks++; if (o_en !== 1'b1) begin failures++; $display("[TB] FAIL reset_en got=%0b exp=1", o_en); end
    checks++; if (o_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", o_data); end
    checks++; if ({o_x_dest, o_y_dest, o_z_dest} !== 5'b0) begin failures++; $display("[TB] FAIL reset_dest got=%b exp=0", {o_x_dest, o_y_dest, o_z_dest}); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      push_one(32'hA0 + 32'(i), 2'(i), 2'(3 - i));
    end
    #1;
    checks++; if (o_count !== 3'd4) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=4", o_count); end
    checks++; if (o_en !== 1'b0) begin failures++; $display("[TB] FAIL fill_en got=%0b exp=0", o_en); end
    // A fifth packet while full must be dropped.
    push_one(32'hEE, 2'd0, 2'd0);
    #1;
    checks++; if (o_count !== 3'd4) begin failures++; $display("[TB] FAIL fill_drop_count got=%0d exp=4", o_count); end
    for (int i = 0; i < 4; i++) begin
      i_grant = 1'b1;
      #1;
      checks++; if (o_data !== 32'hA0 + 32'(i)) begin failures++; $display("[TB] FAIL fill_head%0d_data got=%h exp=%h", i, o_data, 32'hA0 + 32'(i)); end
      checks++; if ({o_x_dest, o_y_dest} !== {2'(i), 2'(3 - i)}) begin failures++; $display("[TB] FAIL fill_head%0d_dest got=%b exp=%b", i, {o_x_dest, o_y_dest}, {2'(i), 2'(3 - i)}); end
      tick();
    end
    i_grant = 1'b0;
    #1;
    checks++; if (o_val !== 1'b0) begin failures++; $display("[TB] FAIL fill_empty_val got=%0b exp=0", o_val); end
    checks++; if (o_count !== 3'd0) begin failures++; $display("[TB] FAIL fill_empty_count got=%0d exp=0", o_count); end
    checks++; if (o_data !== 32'h0) begin failures++; $display("[TB] FAIL fill_empty_data got=%h exp=0", o_data); end
  endtask

  task automatic test_simultaneous();
    push_one(32'h10, 2'd1, 2'd1);
    push_one(32'h11, 2'd2, 2'd2);
    i_val   = 1'b1;
    i_data  = 32'hB0;
    i_grant = 1'b1;
    #1;
    checks++; if (o_data !== 32'h10) begin failures++; $display("[TB] FAIL simul_head_before got=%h exp=10", o_data); end
    tick();
    idle();
    #1;
    checks++; if (o_count !== 3'd2) begin failures++; $display("[TB] FAIL simul_count got=%0d exp=2", o_count); end
    checks++; if (o_data !== 32'h11) begin failures++; $display("[TB] FAIL simul_head_after got=%h exp=11", o_data); end
    push_one(32'hB1, 2'd0, 2'd0);
    push_one(32'hB2, 2'd0, 2'd0);
    // Head is now 0x11; contents 11,B0,B1,B2. Full + grant + i_val.
    i_val   = 1'b1;
    i_data  = 32'hB3;
    i_grant = 1'b1;
    #1;
    checks++; if (o_en !== 1'b0) begin failures++; $display("[TB] FAIL full_pop_en got=%0b exp=0", o_en); end
    tick();
    idle();
    #1;
    checks++; if (o_count !== 3'd3) begin failures++; $display("[TB] FAIL full_pop_count got=%0d exp=3", o_count); end
    for (int i = 0; i < 3; i++) begin
      i_grant = 1'b1;
      #1;
      checks++; if (o_data !== 32'hB0 + 32'(i)) begin failures++; $display("[TB] FAIL full_pop_drain%0d got=%h exp=%h", i, o_data, 32'hB0 + 32'(i)); end
      tick();
    end
    idle();
    #1;
    checks++; if (o_count !== 3'd0) begin failures++; $display("[TB] FAIL full_pop_empty got=%0d exp=0", o_count); end
  endtask

  task automatic test_wrap();
    logic [31:0] q[$];
    for (int i = 0; i < 10; i++) begin
      logic g;
      logic v;
      g = (i > 0) && (i % 3 != 2);
      v = (q.size() < 4);
      i_grant  = g;
      i_val    = v;
      i_data   = 32'hD0 + 32'(i);
      i_x_dest = 2'd3;
      i_y_dest = 2'd1;
      #1;
      checks++; if (o_count !== 3'(q.size())) begin failures++; $display("[TB] FAIL wrap%0d_count got=%0d exp=%0d", i, o_count, q.size()); end
      if (g) begin
        checks++; if ({o_data, o_x_dest, o_y_dest} !== {q[0], 2'd3, 2'd1}) begin failures++; $display("[TB] FAIL wrap%0d_head got=%h/%0d/%0d exp=%h/3/1", i, o_data, o_x_dest, o_y_dest, q[0]); end
        void'(q.pop_front());
      end
      if (v) q.push_back(32'hD0 + 32'(i));
      tick();
    end
    idle();
    while (q.size() > 0) begin
      i_grant = 1'b1;
      #1;
      checks++; if ({o_data, o_x_dest, o_y_dest} !== {q[0], 2'd3, 2'd1}) begin failures++; $display("[TB] FAIL wrap_drain_head got=%h exp=%h", o_data, q[0]); end
      void'(q.pop_front());
      tick();
    end
    idle();
    #1;
    checks++; if (o_val !== 1'b0) begin failures++; $display("[TB] FAIL wrap_end_val got=%0b exp=0", o_val); end
  endtask

  task automatic test_midop_reset();
    push_one(32'h51, 2'd1, 2'd0);
    push_one(32'h52, 2'd1, 2'd0);
    push_one(32'h53, 2'd1, 2'd0);
    #1;
    checks++; if (o_count !== 3'd3) begin failures++; $display("[TB] FAIL midrst_pre_count got=%0d exp=3", o_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (o_count !== 3'd0) begin failures++; $display("[TB] FAIL midrst_count got=%0d exp=0", o_count); end
    checks++; if (o_val !== 1'b0) begin failures++; $display("[TB] FAIL midrst_val got=%0b exp=0", o_val); end
    checks++; if (o_en !== 1'b1) begin failures++; $display("[TB] FAIL midrst_en got=%0b exp=1", o_en); end
  endtask

  task automatic test_bypass();
    i_val    = 1'b1;
    i_data   = 32'hC0;
    i_x_dest = 2'd2;
    i_grant  = 1'b1;
    #1;
`ifdef ENOC_INPUT_BYPASS_EN
    checks++; if (o_val !== 1'b1) begin failures++; $display("[TB] FAIL bypass_val got=%0b exp=1", o_val); end
    checks++; if (o_data !== 32'hC0) begin failures++; $display("[TB] FAIL bypass_data got=%h exp=c0", o_data); end
    tick();
    idle();
    #1;
    checks++; if (o_count !== 3'd0) begin failures++; $display("[TB] FAIL bypass_count got=%0d exp=0", o_count); end
    checks++; if (o_val !== 1'b0) begin failures++; $display("[TB] FAIL bypass_after_val got=%0b exp=0", o_val); end
`else
    checks++; if (o_val !== 1'b0) begin failures++; $display("[TB] FAIL nobypass_val got=%0b exp=0", o_val); end
    tick();
    idle();
    #1;
    checks++; if (o_val !== 1'b1) begin failures++; $display("[TB] FAIL nobypass_next_val got=%0b exp=1", o_val); end
    checks++; if (o_data !== 32'hC0) begin failures++; $display("[TB] FAIL nobypass_next_data got=%h exp=c0", o_data); end
    checks++; if (o_count !== 3'd1) begin failures++; $display("[TB] FAIL nobypass_count got=%0d exp=1", o_count); end
    i_grant = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (o_count !== 3'd0) begin failures++; $display("[TB] FAIL nobypass_drain got=%0d exp=0", o_count); end
`endif
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_fill();
    test_simultaneous();
    test_wrap();
    test_midop_reset();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
